// File: rtl/decode_execute_reg_if.sv
// Decode/execute pipeline-register bus: decode-side fields, hazard controls,
// write-back bypass port, and the registered execute-side copies with counters.
interface decode_execute_reg_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic            valid_d;
    logic [XLEN-1:0] pc_d, pc_plus4_d, imm_d, rd1_d, rd2_d;
    logic [4:0]      rs1_d, rs2_d, rd_d;
    logic            reg_write_d, mem_read_d, mem_write_d, alu_src_d, branch_d, jump_d;
    logic [3:0]      alu_ctrl_d;
    logic [1:0]      result_src_d;

    logic            stall_e, flush_e, cnt_clr;
    logic            reg_write_w;
    logic [4:0]      rd_w;
    logic [XLEN-1:0] result_w;

    logic            valid_e;
    logic [XLEN-1:0] pc_e, pc_plus4_e, imm_e, rd1_e, rd2_e;
    logic [4:0]      rs1_e, rs2_e, rd_e;
    logic            reg_write_e, mem_read_e, mem_write_e, alu_src_e, branch_e, jump_e;
    logic [3:0]      alu_ctrl_e;
    logic [1:0]      result_src_e;
    logic [CNT_W-1:0] bubble_cnt, issue_cnt;

    modport master (
        output valid_d, pc_d, pc_plus4_d, imm_d, rd1_d, rd2_d, rs1_d, rs2_d, rd_d,
               reg_write_d, mem_read_d, mem_write_d, alu_src_d, branch_d, jump_d,
               alu_ctrl_d, result_src_d, stall_e, flush_e, cnt_clr,
               reg_write_w, rd_w, result_w,
        input  valid_e, pc_e, pc_plus4_e, imm_e, rd1_e, rd2_e, rs1_e, rs2_e, rd_e,
               reg_write_e, mem_read_e, mem_write_e, alu_src_e, branch_e, jump_e,
               alu_ctrl_e, result_src_e, bubble_cnt, issue_cnt
    );

    modport slave (
        input  valid_d, pc_d, pc_plus4_d, imm_d, rd1_d, rd2_d, rs1_d, rs2_d, rd_d,
               reg_write_d, mem_read_d, mem_write_d, alu_src_d, branch_d, jump_d,
               alu_ctrl_d, result_src_d, stall_e, flush_e, cnt_clr,
               reg_write_w, rd_w, result_w,
        output valid_e, pc_e, pc_plus4_e, imm_e, rd1_e, rd2_e, rs1_e, rs2_e, rd_e,
               reg_write_e, mem_read_e, mem_write_e, alu_src_e, branch_e, jump_e,
               alu_ctrl_e, result_src_e, bubble_cnt, issue_cnt
    );
endinterface

// File: rtl/decode_execute_reg.sv
// D/E pipeline register: flush > stall > load, write-back bypass on load,
// and saturating bubble/issue performance counters.
module decode_execute_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    decode_execute_reg_if.slave  bus
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic [3:0]      alu_ctrl;
        logic [1:0]      result_src;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stage_t           stage_reg, stage_next, load_val;
    logic             bubble_inc, issue_inc;
    logic             bypass_rs1, bypass_rs2;
    logic [CNT_W-1:0] bubble_cnt_reg, bubble_cnt_next;
    logic [CNT_W-1:0] issue_cnt_reg, issue_cnt_next;

    // Register file writes at the end of the cycle, so the read data on rd*_d is stale.
    assign bypass_rs1 = bus.reg_write_w && (bus.rd_w != 5'd0) && (bus.rd_w == bus.rs1_d);
    assign bypass_rs2 = bus.reg_write_w && (bus.rd_w != 5'd0) && (bus.rd_w == bus.rs2_d);

    always_comb begin
        load_val            = '0;
        load_val.valid      = 1'b1;
        load_val.pc         = bus.pc_d;
        load_val.pc_plus4   = bus.pc_plus4_d;
        load_val.imm        = bus.imm_d;
        load_val.rd1        = bypass_rs1 ? bus.result_w : bus.rd1_d;
        load_val.rd2        = bypass_rs2 ? bus.result_w : bus.rd2_d;
        load_val.rs1        = bus.rs1_d;
        load_val.rs2        = bus.rs2_d;
        load_val.rd         = bus.rd_d;
        load_val.reg_write  = bus.reg_write_d;
        load_val.mem_read   = bus.mem_read_d;
        load_val.mem_write  = bus.mem_write_d;
        load_val.alu_src    = bus.alu_src_d;
        load_val.branch     = bus.branch_d;
        load_val.jump       = bus.jump_d;
        load_val.alu_ctrl   = bus.alu_ctrl_d;
        load_val.result_src = bus.result_src_d;
    end

    // A loaded invalid instruction becomes an all-zero bubble, same as a flush.
    always_comb begin
        stage_next = stage_reg;
        bubble_inc = 1'b0;
        issue_inc  = 1'b0;
        if (bus.flush_e) begin
            stage_next = '0;
            bubble_inc = 1'b1;
        end else if (!bus.stall_e) begin
            if (bus.valid_d) begin
                stage_next = load_val;
                issue_inc  = 1'b1;
            end else begin
                stage_next = '0;
                bubble_inc = 1'b1;
            end
        end
    end

    always_comb begin
        bubble_cnt_next = bubble_cnt_reg;
        issue_cnt_next  = issue_cnt_reg;
        if (bus.cnt_clr) begin
            bubble_cnt_next = '0;
            issue_cnt_next  = '0;
        end else begin
            if (bubble_inc && (bubble_cnt_reg != CNT_MAX))
                bubble_cnt_next = bubble_cnt_reg + 1'b1;
            if (issue_inc && (issue_cnt_reg != CNT_MAX))
                issue_cnt_next = issue_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg      <= '0;
            bubble_cnt_reg <= '0;
            issue_cnt_reg  <= '0;
        end else begin
            stage_reg      <= stage_next;
            bubble_cnt_reg <= bubble_cnt_next;
            issue_cnt_reg  <= issue_cnt_next;
        end
    end

    assign bus.valid_e      = stage_reg.valid;
    assign bus.pc_e         = stage_reg.pc;
    assign bus.pc_plus4_e   = stage_reg.pc_plus4;
    assign bus.imm_e        = stage_reg.imm;
    assign bus.rd1_e        = stage_reg.rd1;
    assign bus.rd2_e        = stage_reg.rd2;
    assign bus.rs1_e        = stage_reg.rs1;
    assign bus.rs2_e        = stage_reg.rs2;
    assign bus.rd_e         = stage_reg.rd;
    assign bus.reg_write_e  = stage_reg.reg_write;
    assign bus.mem_read_e   = stage_reg.mem_read;
    assign bus.mem_write_e  = stage_reg.mem_write;
    assign bus.alu_src_e    = stage_reg.alu_src;
    assign bus.branch_e     = stage_reg.branch;
    assign bus.jump_e       = stage_reg.jump;
    assign bus.alu_ctrl_e   = stage_reg.alu_ctrl;
    assign bus.result_src_e = stage_reg.result_src;
    assign bus.bubble_cnt   = bubble_cnt_reg;
    assign bus.issue_cnt    = issue_cnt_reg;
endmodule

// File: doc/decode_execute_reg.md
DECODE_EXECUTE_REG -- requirements
Module: decode_execute_reg

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter CNT_W, default 16, bubble/issue counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 valid_d  in  1  decode stage holds a real instruction.
REQ-006 pc_d, pc_plus4_d, imm_d  in  XLEN each  decode PC, PC+4, sign-extended immediate.
REQ-007 rd1_d, rd2_d  in  XLEN each  register-file read data for rs1_d/rs2_d.
REQ-008 rs1_d, rs2_d, rd_d  in  5 each  decode register indices.
REQ-009 reg_write_d, mem_read_d, mem_write_d, alu_src_d, branch_d, jump_d  in  1 each  decode control.
REQ-010 alu_ctrl_d  in  4; result_src_d  in  2  decode control.
REQ-011 stall_e  in  1  hold D/E contents.
REQ-012 flush_e  in  1  load bubble into D/E (driven by load-use stall or taken branch/jump).
REQ-013 reg_write_w, rd_w  in  1, 5; result_w  in  XLEN  write-back port for same-cycle bypass.
REQ-014 cnt_clr  in  1  synchronous clear of both counters.
REQ-015 valid_e  out  1; pc_e, pc_plus4_e, imm_e, rd1_e, rd2_e  out  XLEN; rs1_e, rs2_e, rd_e  out  5  registered copies.
REQ-016 reg_write_e, mem_read_e, mem_write_e, alu_src_e, branch_e, jump_e  out  1; alu_ctrl_e  out  4; result_src_e  out  2.
REQ-017 bubble_cnt, issue_cnt  out  CNT_W  performance counters.

Function
REQ-018 All outputs SHALL be registered; latency decode->execute exactly 1 cycle.
REQ-019 Per edge, priority: flush_e > stall_e > load.
REQ-020 Flush: valid_e=0, every control output 0, rs1_e=rs2_e=rd_e=0, all XLEN fields 0.
REQ-021 Stall (flush_e=0): every register holds its value, including valid_e.
REQ-022 Load: all fields capture *_d inputs; valid_e=valid_d.
REQ-023 Load with valid_d=0: contents identical to flush (bubble), so a hazard unit sees rd_e=0 and mem_read_e=0.
REQ-024 Bypass on load: if reg_write_w, rd_w!=0 and rd_w==rs1_d, rd1_e SHALL capture result_w instead of rd1_d; same for rs2_d/rd2_e; both may bypass in one cycle.
REQ-025 Bypass SHALL NOT apply on stall; held data stays unchanged (downstream forwarding covers it).
REQ-026 bubble_cnt increments by 1 on each edge where a bubble is loaded (flush, or load with valid_d=0); not on stall.
REQ-027 issue_cnt increments by 1 on each edge where a valid instruction is loaded.
REQ-028 Both counters saturate at 2^CNT_W-1 (no wrap).
REQ-029 cnt_clr=1 SHALL zero both counters that edge, overriding increment; pipeline fields unaffected.
REQ-030 Stall and flush asserted together SHALL produce a flush.

Reset
REQ-031 rst_n low SHALL immediately (asynchronously) force every output to 0: a bubble with both counters 0.
REQ-032 Reset deasserted mid-operation: first rising edge after release performs a normal load/stall/flush per REQ-019.
REQ-033 Reset SHALL override stall, flush and cnt_clr.

Verification
REQ-034 Load: valid_d=1, pc_d=0x100, rd_d=5, mem_read_d=1, stall/flush=0 -> next cycle valid_e=1, pc_e=0x100, rd_e=5, mem_read_e=1, issue_cnt=1.
REQ-035 Stall: after REQ-034, stall_e=1 for 3 cycles with pc_d=0x104 -> pc_e stays 0x100, counters unchanged.
REQ-036 Flush over stall: stall_e=1, flush_e=1 -> valid_e=0, rd_e=0, mem_read_e=0, bubble_cnt+1.
REQ-037 Bypass: rs1_d=rs2_d=7, rd1_d=rd2_d=0x11, reg_write_w=1, rd_w=7, result_w=0xDEAD -> rd1_e=rd2_e=0xDEAD; repeat with rd_w=0 -> 0x11.
REQ-038 Saturation: CNT_W=4, 20 consecutive flushes -> bubble_cnt=15; cnt_clr=1 with flush -> bubble_cnt=0.
REQ-039 Async reset: drop rst_n between edges while valid_e=1 -> all outputs 0 before next edge.
